// File: rtl/dtw_result_writer.sv
// dtw_result_writer: buffers DTW result words and writes them sequentially
// into the shared result memory, yielding the port whenever the core uses it.
module dtw_result_writer #(
   parameter int BASE_ADDR  = 20,
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_WORDS  = 64
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [DATA_W-1:0] i_res_data,
   input  logic              i_res_valid,
   input  logic              i_res_last,
   output logic              o_res_ready,
   input  logic              i_core_cs_n,
   input  logic              i_core_wr,
   input  logic [ADDR_W-1:0] i_core_addr,
   input  logic [DATA_W-1:0] i_core_wdata,
   output logic              o_mem_cs_n,
   output logic              o_mem_wr,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_done,
   output logic              o_overflow
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(MAX_WORDS + 2);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [CW-1:0] MAXC = CW'(MAX_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

   state_t            state;
   logic [DATA_W:0]   buf_q [FIFO_DEPTH];
   logic [PW:0]       wr_idx;
   logic [PW:0]       rd_idx;
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] eff_ptr;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     eff_cnt;
   logic [DATA_W:0]   head;
   logic              full;
   logic              empty;
   logic              accept;
   logic              pop;
   logic              wr_en;

   assign empty = (wr_idx == rd_idx);
   assign full  = (wr_idx[PW] != rd_idx[PW]) &&
                  (wr_idx[PW-1:0] == rd_idx[PW-1:0]);
   assign head  = buf_q[rd_idx[PW-1:0]];

   assign o_res_ready = !full;
   assign accept      = i_res_valid && !full;
   assign pop         = i_core_cs_n && !empty;

   // An entry popped while still in DONE opens the next set at BASE.
   assign eff_ptr = (state == S_DONE) ? BASE : wptr;
   assign eff_cnt = (state == S_DONE) ? '0 : cnt;
   assign wr_en   = pop && (eff_cnt < MAXC);

   always_comb begin
      o_mem_cs_n  = 1'b1;
      o_mem_wr    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      unique case (1'b1)
         !i_core_cs_n: begin
            o_mem_cs_n  = 1'b0;
            o_mem_wr    = i_core_wr;
            o_mem_addr  = i_core_addr;
            o_mem_wdata = i_core_wdata;
         end
         wr_en: begin
            o_mem_cs_n  = 1'b0;
            o_mem_wr    = 1'b1;
            o_mem_addr  = eff_ptr;
            o_mem_wdata = head[DATA_W-1:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept)
         buf_q[wr_idx[PW-1:0]] <= {i_res_last, i_res_data};
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         wr_idx     <= '0;
         rd_idx     <= '0;
         wptr       <= BASE;
         cnt        <= '0;
         state      <= S_IDLE;
         o_done     <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         if (accept)
            wr_idx <= wr_idx + (PW+1)'(1);
         if (pop)
            rd_idx <= rd_idx + (PW+1)'(1);

         if (state == S_IDLE && accept)
            state <= S_ACTIVE;

         if (state == S_DONE && (accept || pop)) begin
            state      <= S_ACTIVE;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
            wptr       <= BASE;
            cnt        <= '0;
         end

         if (pop) begin
            if (wr_en) begin
               wptr <= eff_ptr + ADDR_W'(1);
               cnt  <= eff_cnt + CW'(1);
            end else begin
               o_overflow <= 1'b1;
            end
            if (head[DATA_W]) begin
               state  <= S_DONE;
               o_done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_dtw_result_writer.sv
// tb_dtw_result_writer: two writers (default and wrap/overflow params) on a
// shared stimulus, checked by a scoreboard fed from a set-level model.
module tb_dtw_result_writer;
   localparam int AW = 10;
   localparam int DW = 32;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          last;
   } wr_t;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic [DW-1:0] res_data = '0;
   logic          res_valid = 1'b0;
   logic          res_last = 1'b0;
   logic          core_cs_n = 1'b1;
   logic          core_wr = 1'b0;
   logic [AW-1:0] core_addr = '0;
   logic [DW-1:0] core_wdata = '0;

   logic          rdy   [2];
   logic          mcs_n [2];
   logic          mwr   [2];
   logic [AW-1:0] maddr [2];
   logic [DW-1:0] mwd   [2];
   logic          mdone [2];
   logic          movf  [2];

   int tests = 0;
   int fails = 0;

   wr_t expq  [2][$];
   bit  doneq [2][$];
   int  n      [2];
   bit  newset [2];
   bit  setovf [2];
   bit  prev_done [2];
   bit  lastw_prev [2];
   bit  drop_chk [2];

   always #5 clk = ~clk;

   dtw_result_writer u_a (
      .clk(clk), .nrst(nrst),
      .i_res_data(res_data), .i_res_valid(res_valid),
      .i_res_last(res_last), .o_res_ready(rdy[0]),
      .i_core_cs_n(core_cs_n), .i_core_wr(core_wr),
      .i_core_addr(core_addr), .i_core_wdata(core_wdata),
      .o_mem_cs_n(mcs_n[0]), .o_mem_wr(mwr[0]),
      .o_mem_addr(maddr[0]), .o_mem_wdata(mwd[0]),
      .o_done(mdone[0]), .o_overflow(movf[0])
   );

   dtw_result_writer #(.BASE_ADDR(1022), .MAX_WORDS(4)) u_b (
      .clk(clk), .nrst(nrst),
      .i_res_data(res_data), .i_res_valid(res_valid),
      .i_res_last(res_last), .o_res_ready(rdy[1]),
      .i_core_cs_n(core_cs_n), .i_core_wr(core_wr),
      .i_core_addr(core_addr), .i_core_wdata(core_wdata),
      .o_mem_cs_n(mcs_n[1]), .o_mem_wr(mwr[1]),
      .o_mem_addr(maddr[1]), .o_mem_wdata(mwd[1]),
      .o_done(mdone[1]), .o_overflow(movf[1])
   );

   function automatic int base_of(int d);
      return (d == 0) ? 20 : 1022;
   endfunction

   function automatic int max_of(int d);
      return (d == 0) ? 64 : 4;
   endfunction

   // Set-level model: word i of a set goes to (BASE + i) mod 1024 if i < MAX.
   task automatic model_accept(int d, logic [DW-1:0] data, logic last);
      wr_t e;
      if (newset[d]) begin
         n[d] = 0;
         setovf[d] = 1'b0;
         newset[d] = 1'b0;
      end
      if (n[d] < max_of(d)) begin
         e.addr = AW'((base_of(d) + n[d]) % 1024);
         e.data = data;
         e.last = last;
         expq[d].push_back(e);
         n[d]++;
      end else begin
         setovf[d] = 1'b1;
      end
      if (last) begin
         doneq[d].push_back(setovf[d]);
         newset[d] = 1'b1;
      end
   endtask

   task automatic model_reset(int d);
      expq[d].delete();
      doneq[d].delete();
      n[d] = 0;
      newset[d] = 1'b1;
      setovf[d] = 1'b0;
      prev_done[d] = 1'b0;
      lastw_prev[d] = 1'b0;
      drop_chk[d] = 1'b0;
   endtask

   task automatic check_dut(int d);
      wr_t e;
      bit  lw;
      bit  eo;
      lw = 1'b0;
      if (!core_cs_n) begin
         tests++;
         if (mcs_n[d] !== 1'b0 || mwr[d] !== core_wr ||
             maddr[d] !== core_addr || mwd[d] !== core_wdata) begin
            fails++;
            $display("FAIL core_pass dut%0d: got cs_n=%b a=%0d d=%h want cs_n=0 a=%0d d=%h",
                     d, mcs_n[d], maddr[d], mwd[d], core_addr, core_wdata);
         end
      end else if (mcs_n[d] === 1'b0) begin
         tests++;
         if (expq[d].size() == 0) begin
            fails++;
            $display("FAIL extra_write dut%0d: got write a=%0d d=%h want none",
                     d, maddr[d], mwd[d]);
         end else begin
            e = expq[d].pop_front();
            lw = e.last;
            if (mwr[d] !== 1'b1 || maddr[d] !== e.addr || mwd[d] !== e.data) begin
               fails++;
               $display("FAIL write dut%0d: got wr=%b a=%0d d=%h want wr=1 a=%0d d=%h",
                        d, mwr[d], maddr[d], mwd[d], e.addr, e.data);
            end
         end
      end else begin
         tests++;
         if (mwr[d] !== 1'b0 || maddr[d] !== '0 || mwd[d] !== '0) begin
            fails++;
            $display("FAIL idle_port dut%0d: got wr=%b a=%0d d=%h want 0,0,0",
                     d, mwr[d], maddr[d], mwd[d]);
         end
      end

      if (drop_chk[d]) begin
         tests++;
         drop_chk[d] = 1'b0;
         if (mdone[d] !== 1'b0) begin
            fails++;
            $display("FAIL done_drop dut%0d: got %b want 0", d, mdone[d]);
         end
      end

      if (lastw_prev[d]) begin
         tests++;
         if (!(mdone[d] === 1'b1 && !prev_done[d])) begin
            fails++;
            $display("FAIL done_timing dut%0d: got done=%b prev=%b want rise",
                     d, mdone[d], prev_done[d]);
         end
      end

      if (mdone[d] === 1'b1 && !prev_done[d]) begin
         tests++;
         if (doneq[d].size() == 0) begin
            fails++;
            $display("FAIL extra_done dut%0d: got done=1 want 0", d);
         end else begin
            eo = doneq[d].pop_front();
            if (movf[d] !== eo) begin
               fails++;
               $display("FAIL overflow dut%0d: got %b want %b", d, movf[d], eo);
            end
         end
      end

      prev_done[d] = (mdone[d] === 1'b1);
      lastw_prev[d] = lw;

      if (res_valid && rdy[d] === 1'b1) begin
         if (mdone[d] === 1'b1)
            drop_chk[d] = 1'b1;
         model_accept(d, res_data, res_last);
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!nrst)
            model_reset(d);
         else
            check_dut(d);
      end
   end

   task automatic check_reset_outputs(string tag);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({mcs_n[d], mwr[d], maddr[d], mwd[d], mdone[d], movf[d], rdy[d]} !==
             {1'b1, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL %s dut%0d: got cs_n=%b wr=%b a=%0d done=%b ovf=%b rdy=%b want 1,0,0,0,0,1",
                     tag, d, mcs_n[d], mwr[d], maddr[d], mdone[d], movf[d], rdy[d]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int c);
      for (int i = 0; i < c; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_word(logic [DW-1:0] data, logic last, bit rnd);
      bit acc;
      int guard;
      acc = 1'b0;
      guard = 0;
      while (!acc) begin
         res_valid = !(rnd && $urandom_range(3) == 0);
         res_data  = res_valid ? data : $urandom;
         res_last  = res_valid ? last : 1'($urandom_range(1));
         if (rnd && $urandom_range(3) == 0) begin
            core_cs_n  = 1'b0;
            core_wr    = 1'($urandom_range(1));
            core_addr  = AW'($urandom);
            core_wdata = $urandom;
         end else begin
            core_cs_n = 1'b1;
         end
         @(negedge clk);
         acc = res_valid && rdy[0] === 1'b1;
         @(posedge clk);
         #1;
         guard++;
         if (!acc && guard > 200) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: got ready=%b want 1", rdy[0]);
            break;
         end
      end
      res_valid = 1'b0;
      res_last  = 1'b0;
      core_cs_n = 1'b1;
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!(mdone[0] === 1'b1 && mdone[1] === 1'b1) && g < 400);
      tests++;
      if (g >= 400) begin
         fails++;
         $display("FAIL done_timeout: got done=%b%b want 11", mdone[0], mdone[1]);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      int len;
      idle(3);
      #1;
      nrst = 1'b1;
      check_reset_outputs("reset_state");
      idle(10);

      for (int i = 0; i < 20; i++)
         push_word(32'h1000 + i, i == 19, 1'b0);
      wait_done();

      k = 0;
      for (int c = 0; c < 8; c++) begin
         core_cs_n  = 1'b0;
         core_wr    = 1'($urandom_range(1));
         core_addr  = AW'($urandom);
         core_wdata = $urandom;
         res_valid  = (k < 6);
         res_data   = 32'h2000 + k;
         res_last   = (k == 5);
         @(negedge clk);
         if (res_valid && rdy[0] === 1'b1)
            k++;
         @(posedge clk);
         #1;
      end
      core_cs_n = 1'b1;
      res_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (k != 4 || rdy[0] !== 1'b0 || rdy[1] !== 1'b0) begin
         fails++;
         $display("FAIL backpressure: got accepts=%0d rdy=%b%b want 4, 00",
                  k, rdy[0], rdy[1]);
      end
      @(posedge clk);
      #1;
      for (int j = k; j < 6; j++)
         push_word(32'h2000 + j, j == 5, 1'b0);
      wait_done();

      push_word(32'hA, 1'b0, 1'b0);
      push_word(32'hB, 1'b0, 1'b0);
      push_word(32'hC, 1'b1, 1'b0);
      wait_done();

      for (int i = 0; i < 66; i++)
         push_word(32'h3000 + i, i == 65, 1'b0);
      wait_done();

      for (int s = 0; s < 8; s++) begin
         len = $urandom_range(10, 1);
         for (int i = 0; i < len; i++)
            push_word($urandom, i == len - 1, 1'b1);
         wait_done();
      end

      core_cs_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         res_valid = 1'b1;
         res_data  = 32'h5000 + i;
         res_last  = 1'b0;
         @(posedge clk);
         #1;
      end
      res_valid = 1'b0;
      nrst = 1'b0;
      idle(2);
      nrst = 1'b1;
      core_cs_n = 1'b1;
      check_reset_outputs("mid_reset");
      idle(10);

      for (int d = 0; d < 2; d++) begin
         tests++;
         if (expq[d].size() != 0 || doneq[d].size() != 0) begin
            fails++;
            $display("FAIL drain dut%0d: got %0d writes %0d dones pending want 0",
                     d, expq[d].size(), doneq[d].size());
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
